// File: rtl/systolic_pkg.sv
// Constants shared across the systolic convolution array: operand width and PE defaults.
package systolic_pkg;

  localparam int unsigned PIX_W        = 8;
  localparam int unsigned PE_K_LEN_DEF = 9;
  localparam int unsigned PE_ACC_W_DEF = 16;

endpackage : systolic_pkg

// File: rtl/pe_mac_if.sv
// Operand forwarding and window-result bundle of one processing element.
interface pe_mac_if
  import systolic_pkg::*;
#(
  parameter int unsigned ACC_W = PE_ACC_W_DEF
);

  logic [PIX_W-1:0] a_in;
  logic [PIX_W-1:0] b_in;
  logic             valid_in;
  logic             clear;
  logic [PIX_W-1:0] a_out;
  logic [PIX_W-1:0] b_out;
  logic             valid_out;
  logic [ACC_W-1:0] result;
  logic             result_valid;
  logic             sat;

  modport master (
    output a_in, b_in, valid_in, clear,
    input  a_out, b_out, valid_out, result, result_valid, sat
  );

  modport slave (
    input  a_in, b_in, valid_in, clear,
    output a_out, b_out, valid_out, result, result_valid, sat
  );

endinterface : pe_mac_if

// File: rtl/multu8.sv
// Unsigned 8x8 multiplier keeping the low operand-width bits of the product.
module multu8
  import systolic_pkg::*;
(
  input  logic [PIX_W-1:0] a_i,
  input  logic [PIX_W-1:0] b_i,
  output logic [PIX_W-1:0] p_c
);

  logic [2*PIX_W-1:0] full_c;

  assign full_c = (2*PIX_W)'(a_i) * (2*PIX_W)'(b_i);
  assign p_c    = full_c[PIX_W-1:0];

endmodule : multu8

// File: rtl/pe_mac.sv
// Output-stationary PE: forwards operands east/south and accumulates K_LEN products
// per window into a saturating sum reported with a one-cycle strobe.
module pe_mac
  import systolic_pkg::*;
#(
  parameter int unsigned K_LEN = PE_K_LEN_DEF,
  parameter int unsigned ACC_W = PE_ACC_W_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  pe_mac_if.slave  bus
);

  localparam int unsigned      CNT_W    = $clog2(K_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K_LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;

  logic [PIX_W-1:0] a_q, b_q;
  logic             valid_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             sat_q, sat_d;

  logic [PIX_W-1:0] p_c;
  logic [ACC_W:0]   sum_c;
  logic             ovf_c;
  logic [ACC_W-1:0] acc_sat_c;
  logic             beat_c;
  logic             last_c;

  multu8 u_mult (
    .a_i (bus.a_in),
    .b_i (bus.b_in),
    .p_c (p_c)
  );

  // One extra sum bit exposes the carry used to clamp at the accumulator maximum.
  assign sum_c     = {1'b0, acc_q} + (ACC_W+1)'(p_c);
  assign ovf_c     = sum_c[ACC_W];
  assign acc_sat_c = ovf_c ? ACC_MAX : sum_c[ACC_W-1:0];
  assign beat_c    = bus.valid_in & ~bus.clear;
  assign last_c    = beat_c & (cnt_q == CNT_LAST);

  always_comb begin
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    flag_d         = flag_q;
    result_d       = result_q;
    sat_d          = sat_q;
    result_valid_d = 1'b0;

    if (bus.clear) begin
      acc_d  = '0;
      cnt_d  = '0;
      flag_d = 1'b0;
    end else if (last_c) begin
      // Window completes: report and restart with no gap cycle.
      result_d       = acc_sat_c;
      sat_d          = flag_q | ovf_c;
      result_valid_d = 1'b1;
      acc_d          = '0;
      cnt_d          = '0;
      flag_d         = 1'b0;
    end else if (beat_c) begin
      acc_d  = acc_sat_c;
      cnt_d  = cnt_q + CNT_W'(1);
      flag_d = flag_q | ovf_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q            <= '0;
      b_q            <= '0;
      valid_q        <= 1'b0;
      acc_q          <= '0;
      cnt_q          <= '0;
      flag_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      sat_q          <= 1'b0;
    end else begin
      a_q            <= bus.a_in;
      b_q            <= bus.b_in;
      valid_q        <= bus.valid_in;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      flag_q         <= flag_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      sat_q          <= sat_d;
    end
  end

  assign bus.a_out        = a_q;
  assign bus.b_out        = b_q;
  assign bus.valid_out    = valid_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.sat          = sat_q;

endmodule : pe_mac

// File: tb/tb_pe_mac.sv
// Scoreboard bench for pe_mac: three configurations share one stimulus stream.
module tb_pe_mac;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  longint cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: K_LEN=1 ACC_W=16, 1: K_LEN=9 ACC_W=16, 2: K_LEN=9 ACC_W=10
  pe_mac_if #(.ACC_W(16)) if1  ();
  pe_mac_if #(.ACC_W(16)) if9  ();
  pe_mac_if #(.ACC_W(10)) if10 ();

  pe_mac #(.K_LEN(1), .ACC_W(16)) u_k1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  pe_mac #(.K_LEN(9), .ACC_W(16)) u_k9  (.clk(clk), .rst_n(rst_n), .bus(if9));
  pe_mac #(.K_LEN(9), .ACC_W(10)) u_w10 (.clk(clk), .rst_n(rst_n), .bus(if10));

  typedef struct {
    longint res;
    bit     sat;
    longint cyc;
  } exp_t;

  exp_t   sb [3][$];
  longint k_len   [3] = '{1, 9, 9};
  longint acc_max [3] = '{65535, 65535, 1023};
  longint m_acc   [3] = '{0, 0, 0};
  longint m_cnt   [3] = '{0, 0, 0};
  bit     m_flag  [3] = '{0, 0, 0};

  logic [7:0] smp_a, smp_b;
  logic       smp_v;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0d exp=%0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Expected forwarded values: the inputs captured at the last rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_a <= '0;
      smp_b <= '0;
      smp_v <= 1'b0;
    end else begin
      smp_a <= if9.a_in;
      smp_b <= if9.b_in;
      smp_v <= if9.valid_in;
    end
  end

  task automatic mon(input int i, input logic [7:0] ao, input logic [7:0] bo, input logic vo,
                     input logic rv, input longint res, input logic s);
    bit   exp_rv;
    exp_t e;
    check_eq($sformatf("dut%0d_a_out", i), ao, smp_a);
    check_eq($sformatf("dut%0d_b_out", i), bo, smp_b);
    check_eq($sformatf("dut%0d_valid_out", i), vo, smp_v);
    exp_rv = (sb[i].size() != 0) && (sb[i][0].cyc <= cyc);
    check_eq($sformatf("dut%0d_result_valid", i), rv, exp_rv);
    if (exp_rv) begin
      e = sb[i].pop_front();
      check_eq($sformatf("dut%0d_result", i), res, e.res);
      check_eq($sformatf("dut%0d_sat", i), s, e.sat);
    end
  endtask

  always @(negedge clk) begin
    mon(0, if1.a_out,  if1.b_out,  if1.valid_out,  if1.result_valid,  if1.result,  if1.sat);
    mon(1, if9.a_out,  if9.b_out,  if9.valid_out,  if9.result_valid,  if9.result,  if9.sat);
    mon(2, if10.a_out, if10.b_out, if10.valid_out, if10.result_valid, if10.result, if10.sat);
  end

  task automatic model_step(input int i, input logic [7:0] a, input logic [7:0] b,
                            input logic v, input logic c);
    longint p, s;
    bit     of;
    exp_t   e;
    if (c) begin
      m_acc[i] = 0; m_cnt[i] = 0; m_flag[i] = 0;
    end else if (v) begin
      p  = (longint'(a) * longint'(b)) % 256;
      s  = m_acc[i] + p;
      of = (s > acc_max[i]);
      if (of) s = acc_max[i];
      m_flag[i] = m_flag[i] | of;
      if (m_cnt[i] == k_len[i] - 1) begin
        e.res = s; e.sat = m_flag[i]; e.cyc = cyc + 1;
        sb[i].push_back(e);
        m_acc[i] = 0; m_cnt[i] = 0; m_flag[i] = 0;
      end else begin
        m_acc[i] = s;
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic v, input logic c);
    @(posedge clk); #1;
    if1.a_in  = a; if1.b_in  = b; if1.valid_in  = v; if1.clear  = c;
    if9.a_in  = a; if9.b_in  = b; if9.valid_in  = v; if9.clear  = c;
    if10.a_in = a; if10.b_in = b; if10.valid_in = v; if10.clear = c;
    for (int i = 0; i < 3; i++) model_step(i, a, b, v, c);
  endtask

  task automatic beats(input int n, input logic [7:0] a, input logic [7:0] b);
    for (int k = 0; k < n; k++) drive(a, b, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(8'd0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0; m_cnt[i] = 0; m_flag[i] = 0;
      sb[i].delete();
    end
  endtask

  initial begin
    if1.a_in  = '0; if1.b_in  = '0; if1.valid_in  = 1'b0; if1.clear  = 1'b0;
    if9.a_in  = '0; if9.b_in  = '0; if9.valid_in  = 1'b0; if9.clear  = 1'b0;
    if10.a_in = '0; if10.b_in = '0; if10.valid_in = 1'b0; if10.clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_result", if1.result, 0);
    check_eq("rst_result_valid", if9.result_valid, 0);
    check_eq("rst_sat", if10.sat, 0);
    rst_n = 1'b1;

    // Single beat: forwarding and K_LEN=1 completion
    drive(8'd64, 8'd10, 1'b1, 1'b0);
    idle(2);
    check_eq("t1_k1_result", if1.result, 128);
    drive(8'd0, 8'd0, 1'b0, 1'b1);

    // Back-to-back windows
    beats(9, 8'd2, 8'd3);
    idle(2);
    check_eq("t2_result", if9.result, 54);
    check_eq("t2_sat", if9.sat, 0);
    beats(9, 8'd1, 8'd1);
    idle(2);
    check_eq("t2b_result", if9.result, 9);

    // Window spread over idle gaps
    for (int k = 0; k < 9; k++) begin
      drive(8'd2, 8'd3, 1'b1, 1'b0);
      idle(2);
    end
    check_eq("t3_result", if9.result, 54);

    // Saturation in the narrow accumulator
    beats(9, 8'd15, 8'd17);
    idle(2);
    check_eq("t4_w10_result", if10.result, 1023);
    check_eq("t4_w10_sat", if10.sat, 1);
    check_eq("t4_k9_result", if9.result, 2295);
    beats(9, 8'd1, 8'd1);
    idle(2);
    check_eq("t4b_w10_result", if10.result, 9);
    check_eq("t4b_w10_sat", if10.sat, 0);

    // Clear coinciding with a beat aborts the window
    beats(5, 8'd2, 8'd3);
    drive(8'd2, 8'd3, 1'b1, 1'b1);
    beats(9, 8'd1, 8'd2);
    idle(2);
    check_eq("t5_result", if9.result, 18);

    // Reset mid-window
    beats(4, 8'd1, 8'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    if1.valid_in = 1'b0; if9.valid_in = 1'b0; if10.valid_in = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_eq("t6_rst_result", if1.result, 0);
    check_eq("t6_rst_a_out", if9.a_out, 0);
    check_eq("t6_rst_valid_out", if9.valid_out, 0);
    check_eq("t6_rst_sat", if10.sat, 0);
    rst_n = 1'b1;
    beats(9, 8'd1, 8'd1);
    idle(3);
    check_eq("t6_result", if9.result, 9);

    for (int i = 0; i < 3; i++)
      check_eq($sformatf("dut%0d_pending", i), sb[i].size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pe_mac

// File: doc/pe_mac.md
# pe_mac

Output-stationary processing element for the systolic convolution array; sits directly downstream of `multu8` and consumes its 8-bit product. Each cycle it forwards its pixel/weight operands to the east/south neighbours, accumulates `multu8` products over one kernel window of `K_LEN` valid beats, and emits the saturated window sum with a one-cycle strobe. One instance per array cell.

## Interface
- `K_LEN`, 9: valid beats per window (3×3 kernel); legal range 1..255.
- `ACC_W`, 16: accumulator and result width; legal range 8..32.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a_in`  in  8  pixel operand from the west neighbour.
- `b_in`  in  8  weight operand from the north neighbour.
- `valid_in`  in  1  `a_in` and `b_in` form a valid beat.
- `clear`  in  1  synchronous window abort; clears accumulator and beat count.
- `a_out`  out  8  registered `a_in` to the east neighbour.
- `b_out`  out  8  registered `b_in` to the south neighbour.
- `valid_out`  out  1  registered `valid_in`.
- `result`  out  `ACC_W`  last completed window sum; held until the next completion.
- `result_valid`  out  1  one-cycle strobe when `result` is updated.
- `sat`  out  1  sticky per window; set if any add in the reported window saturated; valid with `result_valid`.

## Operation
- Product `p` = `multu8(a_in, b_in)` = (`a_in` × `b_in`) mod 256, unsigned 8 bits; zero-extend to `ACC_W`.
- Beat (`valid_in`=1, `clear`=0): `acc` ← min(`acc` + `p`, 2^`ACC_W`−1). The saturation flag is ORed into the window flag. `cnt` ← `cnt`+1.
- Last beat of window (`cnt` = `K_LEN`−1 on a beat): `result` ← saturated `acc`+`p`, `sat` ← window flag, `result_valid` ← 1. `acc`, `cnt` and the window flag are reset to 0 in the same edge, so the next beat starts a fresh window with no gap cycle.
- `K_LEN`=1: every beat completes a window.
- `clear`=1: `acc`, `cnt` and the window flag ← 0. A beat presented in the same cycle is forwarded on `a_out`/`b_out`/`valid_out` but not accumulated. `result`, `sat` and `result_valid` are unaffected, so no strobe is issued.
- No-beat cycles: `acc` and `cnt` hold. Windows may be spread across gaps of any length.
- No backpressure. An unread `result` is overwritten by the next completion.
- Forwarding is unconditional: `a_out`/`b_out`/`valid_out` follow the inputs regardless of `valid_in` or `clear`.
- States are implied by `cnt`: IDLE (`cnt`=0), ACCUM (0<`cnt`<`K_LEN`), with completion returning to IDLE. No separate FSM register.

## Timing
- Reset values: `a_out`=0, `b_out`=0, `valid_out`=0, `result`=0, `result_valid`=0, `sat`=0. Internal `acc`=0, `cnt`=0, window flag=0.
- Forward latency: 1 cycle, input to `a_out`/`b_out`/`valid_out`.
- Result latency: the beat sampled at edge N updates `result` and raises `result_valid` after edge N. The strobe drops after edge N+1 unless another window completes there.
- `result_valid` is never high for two consecutive cycles unless `K_LEN`=1 with back-to-back beats.
- Reset asserted mid-window discards the partial window. On deassertion the next beat is beat 0.
- Throughput: one beat per cycle sustained.

## Structure
- Shared package `systolic_pkg` holds the defaults `PE_K_LEN_DEF`=9 and `PE_ACC_W_DEF`=16, plus the operand width constant `PIX_W`=8, which is shared with `multu8` and the array top.
- Sub-module: one instance of the existing `multu8` for the product. The saturating adder is inline.
- `cnt` width: $clog2(`K_LEN`+1).

## Test plan
- Reset, then `a_in`=64, `b_in`=10, one beat -> `a_out`=64, `b_out`=10, `valid_out`=1 one cycle later. With `K_LEN`=1, `result`=128 (640 mod 256) and `result_valid` pulses once.
- `K_LEN`=9, nine back-to-back beats of `a_in`=2, `b_in`=3 -> `result`=54, `sat`=0, single strobe. A following nine beats of 1×1 -> `result`=9.
- `K_LEN`=9, beats of 2×3 interleaved with idle cycles (pattern 1 on, 2 off) -> `result`=54, strobe one cycle after the ninth beat only.
- `ACC_W`=10, `K_LEN`=9, nine beats of `a_in`=15, `b_in`=17 (`p`=255) -> `result`=1023, `sat`=1. The next window of 9×(1×1) -> `result`=9, `sat`=0.
- `K_LEN`=9, five beats of 2×3, then `clear` together with a beat, then nine beats of 1×2 -> no strobe at the clear, then `result`=18. The cleared-cycle beat still appears on `valid_out`.
- Assert `rst_n`=0 after four beats, release, then nine beats of 1×1 -> `result`=9, and all outputs read 0 during reset.
